transpose_stream_ctrl: RTL and testbench

Streaming matrix-transpose sequencer for the dotinator datapath.
- Accepts a ROW_SIZE x COL_SIZE matrix one row per beat over a valid/ready input.
- Buffers each matrix in one of two ping-pong banks.
- Emits the transposed matrix one column per beat over a valid/ready output.
- Full throughput: bank A fills while bank B drains.

---
 rtl/transpose_pkg.sv | 17 +
 rtl/transpose_bank.sv | 45 ++++
 rtl/transpose_stream_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_transpose_stream_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transpose_pkg.sv
// Shared types and helpers for the streaming transpose controller.
//   bank_state_e : lifecycle of one ping-pong bank
//   cnt_w()      : counter width for an n-entry index, never below 1 bit
package transpose_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_e;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/transpose_bank.sv
// One matrix buffer: ROW_SIZE x COL_SIZE elements of plain register storage.
//   clk     : write clock
//   we      : write enable for row wr_row
//   wr_row  : row index being written
//   wr_data : row data, element c at [c*DATA_WIDTH +: DATA_WIDTH]
//   rd_col  : column index to read
//   rd_data : column data, element r at [r*DATA_WIDTH +: DATA_WIDTH]
// Storage is intentionally not reset; the controller tracks validity.
module transpose_bank
    import transpose_pkg::*;
#(
    parameter int unsigned ROW_SIZE   = 4,
    parameter int unsigned COL_SIZE   = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             we,
    input  logic [cnt_w(ROW_SIZE)-1:0]       wr_row,
    input  logic [COL_SIZE*DATA_WIDTH-1:0]   wr_data,
    input  logic [cnt_w(COL_SIZE)-1:0]       rd_col,
    output logic [ROW_SIZE*DATA_WIDTH-1:0]   rd_data
);

    logic [COL_SIZE*DATA_WIDTH-1:0] mem_q [ROW_SIZE];

    always_ff @(posedge clk) begin
        for (int r = 0; r < ROW_SIZE; r++) begin
            if (we && (int'(wr_row) == r)) begin
                mem_q[r] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < ROW_SIZE; r++) begin
            for (int c = 0; c < COL_SIZE; c++) begin
                if (int'(rd_col) == c) begin
                    rd_data[r*DATA_WIDTH +: DATA_WIDTH] = mem_q[r][c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/transpose_stream_ctrl.sv
// Streaming matrix-transpose sequencer with two ping-pong banks.
//   clk, rst_n          : clock, asynchronous active-low reset
//   flush               : synchronous abort of all buffered data
//   in_valid/in_ready   : row input handshake; in_row carries one row, in_last is advisory
//   out_valid/out_ready : column output handshake; out_col carries one column
//   out_last            : marks the final column of a matrix
//   err_framing/err_clr : sticky in_last/row-count disagreement flag and its clear
// All outputs come straight from flops, so nothing on the output side depends
// combinationally on the input handshake.
module transpose_stream_ctrl
    import transpose_pkg::*;
#(
    parameter int unsigned ROW_SIZE   = 4,
    parameter int unsigned COL_SIZE   = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [COL_SIZE*DATA_WIDTH-1:0] in_row,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ROW_SIZE*DATA_WIDTH-1:0] out_col,
    output logic                           out_last,
    output logic                           err_framing,
    input  logic                           err_clr
);

    localparam int unsigned RowW = cnt_w(ROW_SIZE);
    localparam int unsigned ColW = cnt_w(COL_SIZE);
    localparam logic [RowW-1:0] RowLast = RowW'(ROW_SIZE - 1);
    localparam logic [ColW-1:0] ColLast = ColW'(COL_SIZE - 1);

    bank_state_e state_q [2];
    bank_state_e state_d [2];
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [RowW-1:0] row_cnt_q, row_cnt_d;
    logic [ColW-1:0] col_cnt_q, col_cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            err_q, err_d;
    logic [ROW_SIZE*DATA_WIDTH-1:0] out_col_q, out_col_d;

    logic [1:0]                     bank_we;
    logic [ROW_SIZE*DATA_WIDTH-1:0] bank_rd [2];
    logic [ROW_SIZE*DATA_WIDTH-1:0] rd_sel;
    logic                           in_fire;
    logic                           out_fire;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        transpose_bank #(
            .ROW_SIZE   (ROW_SIZE),
            .COL_SIZE   (COL_SIZE),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk     (clk),
            .we      (bank_we[b]),
            .wr_row  (row_cnt_q),
            .wr_data (in_row),
            .rd_col  (col_cnt_d),
            .rd_data (bank_rd[b])
        );
    end

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid_q && out_ready;

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
        end
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        err_d     = err_q;
        bank_we   = '0;

        // A new error beats a concurrent clear; flushed beats are not judged.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (in_fire && !flush && (in_last != (row_cnt_q == RowLast))) begin
            err_d = 1'b1;
        end

        if (flush) begin
            for (int b = 0; b < 2; b++) begin
                state_d[b] = EMPTY;
            end
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            row_cnt_d = '0;
            col_cnt_d = '0;
        end else begin
            // Writer targets an EMPTY/FILLING bank and reader a FULL/DRAINING one,
            // so both updates below always touch different banks.
            if (in_fire) begin
                bank_we[wr_bank_q] = 1'b1;
                if (row_cnt_q == RowLast) begin
                    state_d[wr_bank_q] = FULL;
                    row_cnt_d          = '0;
                    wr_bank_d          = ~wr_bank_q;
                end else begin
                    state_d[wr_bank_q] = FILLING;
                    row_cnt_d          = row_cnt_q + RowW'(1);
                end
            end
            if (out_fire) begin
                if (col_cnt_q == ColLast) begin
                    state_d[rd_bank_q] = EMPTY;
                    col_cnt_d          = '0;
                    rd_bank_d          = ~rd_bank_q;
                end else begin
                    state_d[rd_bank_q] = DRAINING;
                    col_cnt_d          = col_cnt_q + ColW'(1);
                end
            end
        end

        in_ready_d  = (state_d[wr_bank_d] == EMPTY) || (state_d[wr_bank_d] == FILLING);
        out_valid_d = (state_d[rd_bank_d] == FULL) || (state_d[rd_bank_d] == DRAINING);
        out_last_d  = out_valid_d && (col_cnt_d == ColLast);
    end

    // Next output column. The last row of a matrix lands in the bank on the same
    // edge that makes it readable, so that row's element is taken from in_row.
    assign rd_sel = rd_bank_d ? bank_rd[1] : bank_rd[0];

    always_comb begin
        out_col_d = rd_sel;
        for (int r = 0; r < ROW_SIZE; r++) begin
            for (int c = 0; c < COL_SIZE; c++) begin
                if (bank_we[rd_bank_d] && (int'(row_cnt_q) == r) && (int'(col_cnt_d) == c)) begin
                    out_col_d[r*DATA_WIDTH +: DATA_WIDTH] = in_row[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        if (!out_valid_d) begin
            out_col_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0]  <= EMPTY;
            state_q[1]  <= EMPTY;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            row_cnt_q   <= '0;
            col_cnt_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_col_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q[0]  <= state_d[0];
            state_q[1]  <= state_d[1];
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            row_cnt_q   <= row_cnt_d;
            col_cnt_q   <= col_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_col_q   <= out_col_d;
            err_q       <= err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign out_col     = out_col_q;
    assign err_framing = err_q;

endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// Self-checking bench for transpose_stream_ctrl (4x4x32). A queue-based model
// collects accepted rows, transposes each completed matrix and checks every
// output beat in order; directed scenarios cover latency, throughput,
// backpressure, framing, flush and asynchronous reset.
module tb_transpose_stream_ctrl;

    localparam int R = 4;
    localparam int C = 4;
    localparam int W = 32;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [C*W-1:0] in_row;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [R*W-1:0] out_col;
    logic           out_last;
    logic           err_framing;
    logic           err_clr;

    transpose_stream_ctrl #(
        .ROW_SIZE   (R),
        .COL_SIZE   (C),
        .DATA_WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_row      (in_row),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_col     (out_col),
        .out_last    (out_last),
        .err_framing (err_framing),
        .err_clr     (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [R*W-1:0] col;
        logic           last;
    } beat_t;

    beat_t          exp_q[$];
    logic [C*W-1:0] part_rows[$];
    int             n_checks = 0;
    int             n_errors = 0;
    int             out_beats = 0;
    int             n_lasts = 0;
    int             stalls = 0;
    logic           hold_pending = 1'b0;
    logic [R*W-1:0] hold_col = '0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [C*W-1:0] make_row(input int base, input int stride, input int r);
        logic [C*W-1:0] row;
        for (int c = 0; c < C; c++) begin
            row[c*W +: W] = 32'(base + stride * r + c);
        end
        return row;
    endfunction

    // Reference model: observe each edge's handshakes half a cycle before it.
    always @(negedge clk) begin
        beat_t          b;
        logic [C*W-1:0] row_tmp;
        if (!rst_n) begin
            exp_q.delete();
            part_rows.delete();
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_col", out_col, hold_col);
            end
            hold_pending = 1'b0;
            if (flush) begin
                exp_q.delete();
                part_rows.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("out_spurious", out_valid, 0);
                    end else begin
                        b = exp_q.pop_front();
                        check_eq("out_col", out_col, b.col);
                        check_eq("out_last", out_last, b.last);
                        out_beats++;
                        if (b.last) n_lasts++;
                    end
                end
                if (out_valid && !out_ready) begin
                    hold_pending = 1'b1;
                    hold_col     = out_col;
                end
                if (in_valid && in_ready) begin
                    part_rows.push_back(in_row);
                    if (part_rows.size() == R) begin
                        for (int c = 0; c < C; c++) begin
                            b.col = '0;
                            for (int r = 0; r < R; r++) begin
                                row_tmp = part_rows[r];
                                b.col[r*W +: W] = row_tmp[c*W +: W];
                            end
                            b.last = (c == C - 1);
                            exp_q.push_back(b);
                        end
                        part_rows.delete();
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the row is accepted.
    task automatic drive_row(input logic [C*W-1:0] row, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_row   = row;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        stalls += waited;
        if (!in_ready) check_eq("in_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_valid", out_valid, 0);
        check_eq("drain_queue", exp_q.size(), 0);
    endtask

    initial begin
        int b0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_row = '0; in_last = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0;
        #12;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_err", err_framing, 0);
        check_eq("rst_out_col", out_col, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("rel_in_ready", in_ready, 0);
        @(posedge clk);
        #1 check_eq("first_edge_in_ready", in_ready, 1);

        // Single matrix, element (r,c) = 16r+c
        out_ready = 1'b1;
        for (int r = 0; r < R; r++) begin
            drive_row(make_row(0, 16, r), r == R - 1);
            if (r == R - 2) check_eq("lat_pre", out_valid, 0);
            if (r == R - 1) check_eq("lat_valid", out_valid, 1);
        end
        wait_drain();
        check_eq("s1_beats", out_beats, 4);
        check_eq("s1_lasts", n_lasts, 1);

        // Three back-to-back matrices, no input stalls
        stalls = 0;
        b0 = out_beats;
        for (int m = 0; m < 3; m++) begin
            for (int r = 0; r < R; r++) drive_row(make_row(m * 256, 16, r), r == R - 1);
        end
        check_eq("b2b_stalls", stalls, 0);
        wait_drain();
        check_eq("b2b_beats", out_beats - b0, 12);
        check_eq("b2b_lasts", n_lasts, 4);

        // Full backpressure: both banks fill, ninth row is held
        out_ready = 1'b0;
        b0 = out_beats;
        for (int k = 0; k < 8; k++) drive_row(make_row((k / 4) * 256 + 16, 16, k % 4), (k % 4) == 3);
        check_eq("bp_in_ready", in_ready, 0);
        in_valid = 1'b1;
        in_row   = make_row(2 * 256 + 16, 16, 0);
        in_last  = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_eq("bp_in_ready_hold", in_ready, 0);
        out_ready = 1'b1;
        for (int k = 8; k < 12; k++) drive_row(make_row(2 * 256 + 16, 16, k % 4), (k % 4) == 3);
        wait_drain();
        check_eq("bp_beats", out_beats - b0, 12);

        // Framing: early in_last, then missing in_last
        check_eq("err_idle", err_framing, 0);
        for (int r = 0; r < R; r++) begin
            drive_row(make_row(32'h700, 16, r), (r == 1) || (r == 3));
            if (r == 0) check_eq("err_before", err_framing, 0);
            if (r >= 1) check_eq("err_sticky", err_framing, 1);
        end
        wait_drain();
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        check_eq("err_cleared", err_framing, 0);
        for (int r = 0; r < R; r++) begin
            drive_row(make_row(32'h800, 16, r), 1'b0);
            if (r == R - 2) check_eq("err_nolast_pre", err_framing, 0);
            if (r == R - 1) check_eq("err_nolast", err_framing, 1);
        end
        wait_drain();
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        check_eq("err_cleared2", err_framing, 0);

        // Flush during drain of matrix 0 and fill of matrix 1
        out_ready = 1'b0;
        b0 = out_beats;
        for (int r = 0; r < R; r++) drive_row(make_row(32'h300, 16, r), r == R - 1);
        for (int r = 0; r < 2; r++) drive_row(make_row(32'h400, 16, r), 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        check_eq("mid_drain_valid", out_valid, 1);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_row   = make_row(32'hDEAD, 1, 0);
        in_last  = 1'b0;
        @(posedge clk);
        #1 flush = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_out_valid", out_valid, 0);
        check_eq("flush_in_ready", in_ready, 1);
        check_eq("flush_out_last", out_last, 0);
        check_eq("flush_err", err_framing, 0);
        out_ready = 1'b1;
        for (int r = 0; r < R; r++) drive_row(make_row(32'hA0, 4, r), r == R - 1);
        wait_drain();
        check_eq("flush_beats", out_beats - b0, 6);

        // Asynchronous reset between edges, mid-drain
        out_ready = 1'b0;
        for (int r = 0; r < R; r++) drive_row(make_row(32'h500, 16, r), r == R - 1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_in_ready", in_ready, 0);
        check_eq("arst_out_col", out_col, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 check_eq("arst_rel_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int r = 0; r < R; r++) begin
            drive_row(make_row(32'h600, 16, r), r == R - 1);
            if (r == R - 2) check_eq("arst_lat_pre", out_valid, 0);
            if (r == R - 1) check_eq("arst_lat_valid", out_valid, 1);
        end
        wait_drain();

        // Randomized traffic with random gaps and random backpressure
        fork
            begin
                for (int m = 0; m < 5; m++) begin
                    for (int r = 0; r < R; r++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        drive_row({$urandom, $urandom, $urandom, $urandom}, r == R - 1);
                    end
                end
            end
            begin
                repeat (150) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        wait_drain();
        check_eq("final_err", err_framing, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
